timer_ctrl: RTL and testbench

- Control stage directly upstream of the hour/minute/second digit counters in the countdown timer.
- Debounces the three raw pushbuttons and runs the set/run/pause/done mode FSM.
- Issues single-cycle increment strobes to the hour and minute units digits, and decrease strobes to the least-significant digit on each 1 Hz tick.
- Consumes the digit chain's all-zero flag to detect expiry and drive the alarm.

---
 rtl/timer_ctrl.sv | 189 ++++++++++++++++++
 tb/tb_timer_ctrl.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/timer_ctrl.sv
// -----------------------------------------------------------------------------
// timer_ctrl
//   Control stage for the countdown timer. It sits directly in front of the
//   hour/minute/second digit counters.
//   - Conditions the three raw pushbuttons. Each one goes through a
//     synchronizer, a debouncer and a rising-edge one-pulse stage.
//   - Runs the SET_HR / SET_MIN / RUN / PAUSE / DONE mode FSM.
//   - Drives single-cycle digit strobes, the run LED and the alarm.
//
// Ports
//   clk_out   in  1  system clock (same domain as the digit counters)
//   rst_n     in  1  asynchronous active-low reset
//   pb_mode   in  1  raw mode pushbutton (asynchronous level)
//   pb_inc    in  1  raw increment pushbutton (asynchronous level)
//   pb_start  in  1  raw start/pause pushbutton (asynchronous level)
//   tick      in  1  one-cycle 1 Hz enable
//   all_zero  in  1  every digit of the counter chain is 0
//   decrease  out 1  one-cycle strobe to the least-significant digit
//   inc_hour  out 1  one-cycle strobe to the hour units digit
//   inc_min   out 1  one-cycle strobe to the minute units digit
//   state     out 3  current FSM state
//   run_led   out 1  high in RUN
//   alarm     out 1  high in DONE
// -----------------------------------------------------------------------------

// Per-button conditioning: 2-flop sync -> debounce -> rising-edge pulse.
// The pulse is registered, so the total press-to-pulse delay is
// 2 + DB_CYCLES + 1 cycles.
module timer_ctrl_db #(
  parameter int DB_CYCLES = 4
) (
  input  logic clk_out,
  input  logic rst_n,
  input  logic i_raw,
  output logic o_pulse
);
  localparam int CW = (DB_CYCLES < 2) ? 1 : $clog2(DB_CYCLES + 1);

  logic          r_s1, r_s2;
  logic          r_lvl, r_lvl_d, r_pulse;
  logic [CW-1:0] r_cnt;

  always_ff @(posedge clk_out or negedge rst_n) begin
    if (!rst_n) begin
      r_s1    <= 1'b0;
      r_s2    <= 1'b0;
      r_lvl   <= 1'b0;
      r_lvl_d <= 1'b0;
      r_pulse <= 1'b0;
      r_cnt   <= '0;
    end else begin
      r_s1 <= i_raw;
      r_s2 <= r_s1;
      // The level flips only after DB_CYCLES consecutive disagreeing samples.
      // Any agreeing sample restarts the count.
      if (r_s2 != r_lvl) begin
        if (r_cnt == CW'(DB_CYCLES - 1)) begin
          r_lvl <= r_s2;
          r_cnt <= '0;
        end else begin
          r_cnt <= r_cnt + CW'(1);
        end
      end else begin
        r_cnt <= '0;
      end
      r_lvl_d <= r_lvl;
      r_pulse <= r_lvl & ~r_lvl_d;
    end
  end

  assign o_pulse = r_pulse;
endmodule

module timer_ctrl #(
  parameter int DB_CYCLES   = 4,
  parameter int ALARM_TICKS = 10
) (
  input  logic       clk_out,
  input  logic       rst_n,
  input  logic       pb_mode,
  input  logic       pb_inc,
  input  logic       pb_start,
  input  logic       tick,
  input  logic       all_zero,
  output logic       decrease,
  output logic       inc_hour,
  output logic       inc_min,
  output logic [2:0] state,
  output logic       run_led,
  output logic       alarm
);
  localparam int TW = $clog2(ALARM_TICKS + 1);

  typedef enum logic [2:0] {
    S_SET_HR  = 3'd0,
    S_SET_MIN = 3'd1,
    S_RUN     = 3'd2,
    S_PAUSE   = 3'd3,
    S_DONE    = 3'd4
  } state_t;

  // Button lanes, ordered {start, mode, inc}.
  logic [2:0] w_raw;
  logic [2:0] w_p;
  logic       w_p_inc, w_p_mode, w_p_start;

  assign w_raw = {pb_start, pb_mode, pb_inc};

  timer_ctrl_db #(.DB_CYCLES(DB_CYCLES)) u_db [2:0] (
    .clk_out (clk_out),
    .rst_n   (rst_n),
    .i_raw   (w_raw),
    .o_pulse (w_p)
  );

  assign w_p_inc   = w_p[0];
  assign w_p_mode  = w_p[1];
  assign w_p_start = w_p[2];

  state_t        r_state;
  logic [TW-1:0] r_tcnt;
  logic          r_dec, r_inc_h, r_inc_m;

  // All strobes default low every cycle. This keeps them one cycle wide and
  // mutually exclusive, because each state's branch sets at most one of them.
  always_ff @(posedge clk_out or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_SET_HR;
      r_tcnt  <= '0;
      r_dec   <= 1'b0;
      r_inc_h <= 1'b0;
      r_inc_m <= 1'b0;
    end else begin
      r_dec   <= 1'b0;
      r_inc_h <= 1'b0;
      r_inc_m <= 1'b0;
      case (r_state)
        S_SET_HR, S_SET_MIN: begin
          // A start press with nothing loaded is swallowed. It still
          // outranks mode and inc in the same cycle.
          if (w_p_start) begin
            if (!all_zero) r_state <= S_RUN;
          end else if (w_p_mode) begin
            r_state <= (r_state == S_SET_HR) ? S_SET_MIN : S_SET_HR;
          end else if (w_p_inc) begin
            if (r_state == S_SET_HR) r_inc_h <= 1'b1;
            else                     r_inc_m <= 1'b1;
          end
        end
        S_RUN: begin
          if (w_p_start) begin
            r_state <= S_PAUSE;          // a same-cycle tick is dropped
          end else if (all_zero) begin
            r_state <= S_DONE;
            r_tcnt  <= '0;
          end else if (tick) begin
            r_dec <= 1'b1;
          end
        end
        S_PAUSE: begin
          if (w_p_start)     r_state <= S_RUN;
          else if (w_p_mode) r_state <= S_SET_HR;
        end
        S_DONE: begin
          if (w_p_start || w_p_mode || w_p_inc) begin
            r_state <= S_SET_HR;
          end else if (tick) begin
            // Leave on the tick that brings the count to ALARM_TICKS.
            // The counter holds at ALARM_TICKS and never wraps.
            if (r_tcnt >= TW'(ALARM_TICKS - 1)) begin
              r_tcnt  <= TW'(ALARM_TICKS);
              r_state <= S_SET_HR;
            end else begin
              r_tcnt <= r_tcnt + TW'(1);
            end
          end
        end
        default: r_state <= S_SET_HR;
      endcase
    end
  end

  assign decrease = r_dec;
  assign inc_hour = r_inc_h;
  assign inc_min  = r_inc_m;
  assign state    = r_state;
  assign run_led  = (r_state == S_RUN);
  assign alarm    = (r_state == S_DONE);
endmodule

// File: tb/tb_timer_ctrl.sv
// -----------------------------------------------------------------------------
// tb_timer_ctrl
//   Directed bench for timer_ctrl.
//   - Stimulus pushes each expected strobe as {kind, cycle} into a queue.
//   - A negedge monitor pops an entry for every strobe it sees. It flags
//     unexpected, late, missing or mixed strobes.
//   - State and level outputs are checked inline by the stimulus.
// -----------------------------------------------------------------------------
module tb_timer_ctrl;
  logic       clk_out = 1'b0;
  logic       rst_n = 1'b0;
  logic       pb_mode = 1'b0, pb_inc = 1'b0, pb_start = 1'b0;
  logic       tick = 1'b0, all_zero = 1'b0;
  logic       decrease, inc_hour, inc_min, run_led, alarm;
  logic [2:0] state;

  timer_ctrl dut (
    .clk_out  (clk_out),
    .rst_n    (rst_n),
    .pb_mode  (pb_mode),
    .pb_inc   (pb_inc),
    .pb_start (pb_start),
    .tick     (tick),
    .all_zero (all_zero),
    .decrease (decrease),
    .inc_hour (inc_hour),
    .inc_min  (inc_min),
    .state    (state),
    .run_led  (run_led),
    .alarm    (alarm)
  );

  always #5 clk_out = ~clk_out;

  int cyc = 0;
  always @(posedge clk_out) cyc <= cyc + 1;

  localparam int K_DEC = 1, K_IH = 2, K_IM = 4;
  typedef struct { int kind; int cyc; } exp_t;
  exp_t q[$];

  int checks = 0, failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, req);
    end
  endtask

  // Strobe monitor
  logic [2:0] m_s;
  exp_t       m_e;
  always @(negedge clk_out) begin
    m_s = {inc_min, inc_hour, decrease};
    while (q.size() > 0 && q[0].cyc < cyc) begin
      checks++; failures++;
      $display("FAIL missing_strobe actual=none required_kind=%0d at cycle %0d", q[0].kind, q[0].cyc);
      void'(q.pop_front());
    end
    if (m_s != 3'b000) begin
      checks++;
      if (q.size() == 0) begin
        failures++;
        $display("FAIL unexpected_strobe actual_kind=%0d at cycle %0d required=none", m_s, cyc);
      end else begin
        m_e = q.pop_front();
        if (m_e.kind != int'(m_s) || m_e.cyc != cyc) begin
          failures++;
          $display("FAIL strobe actual_kind=%0d cycle=%0d required_kind=%0d cycle=%0d",
                   m_s, cyc, m_e.kind, m_e.cyc);
        end
      end
    end
  end

  task automatic wait_n(input int n);
    repeat (n) @(negedge clk_out);
  endtask

  task automatic push(input int k, input int c);
    exp_t e;
    e.kind = k; e.cyc = c;
    q.push_back(e);
  endtask

  task automatic set_btn(input int b, input logic v);
    case (b)
      0: pb_inc   = v;
      1: pb_mode  = v;
      default: pb_start = v;
    endcase
  endtask

  // Clean press. The FSM acts 8 cycles after the press; release, then settle.
  task automatic press(input int b, input int strobe_kind);
    if (strobe_kind != 0) push(strobe_kind, cyc + 8);
    set_btn(b, 1'b1);
    wait_n(8);
    set_btn(b, 1'b0);
    wait_n(8);
  endtask

  task automatic do_tick(input bit exp_dec);
    if (exp_dec) push(K_DEC, cyc + 1);
    tick = 1'b1;
    wait_n(1);
    tick = 1'b0;
    wait_n(1);
  endtask

  initial begin
    // Reset state
    wait_n(3);
    chk("rst_state", state, 0);
    chk("rst_decrease", decrease, 0);
    chk("rst_inc_hour", inc_hour, 0);
    chk("rst_inc_min", inc_min, 0);
    chk("rst_run_led", run_led, 0);
    chk("rst_alarm", alarm, 0);
    rst_n = 1'b1;
    wait_n(2);

    // Held inc in SET_HR: exactly one inc_hour, 8 cycles after the edge
    push(K_IH, cyc + 8);
    pb_inc = 1'b1;
    wait_n(20);
    pb_inc = 1'b0;
    wait_n(10);
    chk("inc_hold_state", state, 0);

    // SET_MIN increments the minute digit
    press(1, 0);
    chk("to_set_min", state, 1);
    press(0, K_IM);
    chk("set_min_stay", state, 1);
    press(1, 0);
    chk("back_set_hr", state, 0);

    // Bouncing mode button, then stable
    pb_mode = 1'b1; wait_n(1);
    pb_mode = 1'b0; wait_n(1);
    pb_mode = 1'b1; wait_n(1);
    pb_mode = 1'b0; wait_n(1);
    pb_mode = 1'b1;
    wait_n(7);
    chk("bounce_early", state, 0);
    wait_n(1);
    chk("bounce_settled", state, 1);
    wait_n(4);
    pb_mode = 1'b0;
    wait_n(10);
    chk("bounce_once", state, 1);
    press(1, 0);
    chk("mode_return", state, 0);

    // Run with three ticks, then expiry
    all_zero = 1'b0;
    press(2, 0);
    chk("run_state", state, 2);
    chk("run_led_on", run_led, 1);
    repeat (3) begin
      do_tick(1);
      wait_n(2);
    end
    all_zero = 1'b1;
    wait_n(1);
    chk("expire_state", state, 4);
    chk("expire_alarm", alarm, 1);
    chk("expire_run_led", run_led, 0);

    // DONE times out on the 10th tick
    repeat (9) do_tick(0);
    chk("done_after9", state, 4);
    tick = 1'b1;
    wait_n(1);
    tick = 1'b0;
    chk("done_timeout_state", state, 0);
    chk("done_timeout_alarm", alarm, 0);
    wait_n(2);

    // Pause: a tick in the same cycle as the start pulse is dropped
    all_zero = 1'b0;
    press(2, 0);
    chk("run_again", state, 2);
    pb_start = 1'b1;
    wait_n(7);
    tick = 1'b1;
    wait_n(1);
    tick = 1'b0;
    pb_start = 1'b0;
    chk("pause_state", state, 3);
    wait_n(8);
    do_tick(0);
    do_tick(0);
    chk("pause_ignores_tick", state, 3);
    press(2, 0);
    chk("resume_state", state, 2);
    chk("resume_led", run_led, 1);

    // DONE aborted by inc after 4 ticks, with no inc_hour
    all_zero = 1'b1;
    wait_n(1);
    chk("done_again", state, 4);
    repeat (4) do_tick(0);
    pb_inc = 1'b1;
    wait_n(8);
    chk("done_abort", state, 0);
    pb_inc = 1'b0;
    wait_n(10);

    // Start with all_zero in SET_HR is ignored
    press(2, 0);
    chk("start_zero", state, 0);

    // Asynchronous reset mid-RUN with a partly debounced press
    all_zero = 1'b0;
    press(2, 0);
    chk("run_pre_reset", state, 2);
    do_tick(1);
    pb_inc = 1'b1;
    wait_n(4);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_state", state, 0);
    chk("async_rst_led", run_led, 0);
    chk("async_rst_alarm", alarm, 0);
    chk("async_rst_strobes", {inc_min, inc_hour, decrease}, 0);
    wait_n(2);
    pb_inc = 1'b0;
    wait_n(1);
    rst_n = 1'b1;
    wait_n(15);
    chk("post_rst_state", state, 0);

    // Button held through reset release pulses once
    rst_n = 1'b0;
    pb_inc = 1'b1;
    wait_n(2);
    rst_n = 1'b1;
    push(K_IH, cyc + 8);
    wait_n(12);
    pb_inc = 1'b0;
    wait_n(10);

    chk("queue_empty", q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
